// File: rtl/ir_cmp_arbiter.sv
// Round-robin arbiter sharing one N-bit comparator among R requesters.
// Single transaction in flight: IDLE (grant) -> EXEC (compare) -> RESP (hold until taken).
module ir_cmp_arbiter #(
   parameter int unsigned N  = 8,
   parameter int unsigned R  = 4,
   parameter int unsigned IW = (R > 2) ? $clog2(R) : 1
) (
   input  logic           CLK,
   input  logic           RESETN,
   input  logic [R-1:0]   REQ_VALID,
   output logic [R-1:0]   REQ_READY,
   input  logic [4*R-1:0] REQ_OP,
   input  logic [N*R-1:0] REQ_A,
   input  logic [N*R-1:0] REQ_B,
   output logic           RSP_VALID,
   input  logic           RSP_READY,
   output logic [IW-1:0]  RSP_ID,
   output logic           RSP_C,
   output logic           RSP_ERR
);

   typedef enum logic [1:0] {StIdle, StExec, StResp} state_e;

   state_e        state_q, state_d;
   logic [IW-1:0] ptr_q, ptr_d;
   logic [3:0]    op_q, op_d;
   logic [N-1:0]  a_q, a_d;
   logic [N-1:0]  b_q, b_d;
   logic [IW-1:0] id_q, id_d;
   logic          rsp_c_q, rsp_c_d;
   logic          rsp_err_q, rsp_err_d;
   logic [IW-1:0] rsp_id_q, rsp_id_d;

   logic [3:0]    op_arr [R];
   logic [N-1:0]  a_arr  [R];
   logic [N-1:0]  b_arr  [R];

   for (genvar g = 0; g < R; g++) begin : g_unpack
      assign op_arr[g] = REQ_OP[4*g +: 4];
      assign a_arr[g]  = REQ_A[N*g +: N];
      assign b_arr[g]  = REQ_B[N*g +: N];
   end

   // Rotating priority search starting at ptr_q, wrapping at R-1.
   logic          grant_vld;
   logic [IW-1:0] grant_idx;
   logic [R-1:0]  grant_oh;
   logic [IW:0]   srch;

   always_comb begin
      grant_vld = 1'b0;
      grant_idx = '0;
      grant_oh  = '0;
      srch      = '0;
      for (int k = 0; k < R; k++) begin
         srch = {1'b0, ptr_q} + (IW+1)'(k);
         if (srch >= (IW+1)'(R)) begin
            srch = srch - (IW+1)'(R);
         end
         if (!grant_vld && REQ_VALID[srch[IW-1:0]]) begin
            grant_vld = 1'b1;
            grant_idx = srch[IW-1:0];
         end
      end
      if (grant_vld) begin
         grant_oh[grant_idx] = 1'b1;
      end
   end

   logic signed [N-1:0] a_s, b_s;
   logic                cmp_c, cmp_err;

   assign a_s = a_q;
   assign b_s = b_q;

   always_comb begin
      cmp_c   = 1'b0;
      cmp_err = 1'b0;
      case (op_q)
         4'd0:    cmp_c = (a_q >  b_q);
         4'd1:    cmp_c = (a_q >= b_q);
         4'd2:    cmp_c = (a_q <  b_q);
         4'd3:    cmp_c = (a_q <= b_q);
         4'd4:    cmp_c = (a_s >  b_s);
         4'd5:    cmp_c = (a_s >= b_s);
         4'd6:    cmp_c = (a_s <  b_s);
         4'd7:    cmp_c = (a_s <= b_s);
         4'd8:    cmp_c = (a_q == b_q);
         4'd9:    cmp_c = (a_q != b_q);
         default: cmp_err = 1'b1;
      endcase
   end

   always_comb begin
      state_d   = state_q;
      ptr_d     = ptr_q;
      op_d      = op_q;
      a_d       = a_q;
      b_d       = b_q;
      id_d      = id_q;
      rsp_c_d   = rsp_c_q;
      rsp_err_d = rsp_err_q;
      rsp_id_d  = rsp_id_q;
      REQ_READY = '0;
      RSP_VALID = 1'b0;
      case (state_q)
         StIdle: begin
            REQ_READY = grant_oh;
            if (grant_vld) begin
               op_d    = op_arr[grant_idx];
               a_d     = a_arr[grant_idx];
               b_d     = b_arr[grant_idx];
               id_d    = grant_idx;
               ptr_d   = (grant_idx == IW'(R-1)) ? '0 : grant_idx + 1'b1;
               state_d = StExec;
            end
         end
         StExec: begin
            rsp_c_d   = cmp_c;
            rsp_err_d = cmp_err;
            rsp_id_d  = id_q;
            state_d   = StResp;
         end
         StResp: begin
            RSP_VALID = 1'b1;
            if (RSP_READY) begin
               state_d = StIdle;
            end
         end
         default: state_d = StIdle;
      endcase
      // Grant is combinational, so it must be masked while reset is held.
      if (!RESETN) begin
         REQ_READY = '0;
      end
   end

   always_ff @(posedge CLK or negedge RESETN) begin
      if (!RESETN) begin
         state_q   <= StIdle;
         ptr_q     <= '0;
         op_q      <= '0;
         a_q       <= '0;
         b_q       <= '0;
         id_q      <= '0;
         rsp_c_q   <= 1'b0;
         rsp_err_q <= 1'b0;
         rsp_id_q  <= '0;
      end else begin
         state_q   <= state_d;
         ptr_q     <= ptr_d;
         op_q      <= op_d;
         a_q       <= a_d;
         b_q       <= b_d;
         id_q      <= id_d;
         rsp_c_q   <= rsp_c_d;
         rsp_err_q <= rsp_err_d;
         rsp_id_q  <= rsp_id_d;
      end
   end

   assign RSP_C   = rsp_c_q;
   assign RSP_ERR = rsp_err_q;
   assign RSP_ID  = rsp_id_q;

endmodule

// File: tb/tb_ir_cmp_arbiter.sv
// Directed self-checking bench for ir_cmp_arbiter: arbitration order, latency,
// operators, illegal opcodes, backpressure and reset behaviour.
module tb_ir_cmp_arbiter;

   localparam int N  = 8;
   localparam int R  = 4;
   localparam int IW = 2;

   logic           clk = 1'b0;
   logic           resetn;
   logic [R-1:0]   req_valid;
   logic [R-1:0]   req_ready;
   logic [4*R-1:0] req_op;
   logic [N*R-1:0] req_a;
   logic [N*R-1:0] req_b;
   logic           rsp_valid;
   logic           rsp_ready;
   logic [IW-1:0]  rsp_id;
   logic           rsp_c;
   logic           rsp_err;

   int n_tests = 0;
   int n_fail  = 0;

   ir_cmp_arbiter #(.N(N), .R(R)) u_dut (
      .CLK       (clk),
      .RESETN    (resetn),
      .REQ_VALID (req_valid),
      .REQ_READY (req_ready),
      .REQ_OP    (req_op),
      .REQ_A     (req_a),
      .REQ_B     (req_b),
      .RSP_VALID (rsp_valid),
      .RSP_READY (rsp_ready),
      .RSP_ID    (rsp_id),
      .RSP_C     (rsp_c),
      .RSP_ERR   (rsp_err)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic set_req(input int id, input logic [3:0] op, input logic [7:0] a,
                          input logic [7:0] b);
      req_valid[id]     = 1'b1;
      req_op[4*id +: 4] = op;
      req_a[8*id +: 8]  = a;
      req_b[8*id +: 8]  = b;
   endtask

   // Called at negedge+1 with the request already driven.
   task automatic wait_grant(input string tag, input int id, output bit ok);
      ok = 1'b0;
      for (int k = 0; k < 20 && !ok; k++) begin
         if (req_ready[id]) begin
            ok = 1'b1;
         end else begin
            @(negedge clk);
            #1;
         end
      end
      check({tag, "_grant"}, 32'(ok), 32'd1);
   endtask

   task automatic do_req(input string tag, input int id, input logic [3:0] op,
                         input logic [7:0] a, input logic [7:0] b,
                         output logic c, output logic err, output logic [IW-1:0] rid);
      bit ok;
      @(negedge clk);
      set_req(id, op, a, b);
      #1;
      wait_grant(tag, id, ok);
      c   = 1'bx;
      err = 1'bx;
      rid = 'x;
      if (!ok) begin
         req_valid[id] = 1'b0;
         return;
      end
      @(negedge clk);
      req_valid[id] = 1'b0;
      check({tag, "_exec_novalid"}, 32'(rsp_valid), 32'd0);
      @(negedge clk);
      check({tag, "_resp_valid"}, 32'(rsp_valid), 32'd1);
      c   = rsp_c;
      err = rsp_err;
      rid = rsp_id;
   endtask

   initial begin
      logic          c, e;
      logic [IW-1:0] id;
      bit            ok;
      int            grants, rsps, multi, cnt;
      int            gq [6];
      int            rq [6];
      int            rr_exp [6] = '{0, 1, 2, 3, 0, 1};
      logic [7:0]    ff00_exp = 8'b1100_0011;
      logic [3:0]    ffff_op [4] = '{4'd8, 4'd9, 4'd3, 4'd5};
      logic          ffff_exp [4] = '{1'b1, 1'b0, 1'b1, 1'b1};

      resetn    = 1'b0;
      req_valid = '1;
      req_op    = '0;
      req_a     = '0;
      req_b     = '0;
      rsp_ready = 1'b1;

      // Reset state, with all requests valid to show the grant is masked.
      #12;
      check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
      check("rst_rsp_c", 32'(rsp_c), 32'd0);
      check("rst_rsp_err", 32'(rsp_err), 32'd0);
      check("rst_rsp_id", 32'(rsp_id), 32'd0);
      check("rst_req_ready", 32'(req_ready), 32'd0);
      req_valid = '0;
      @(negedge clk);
      resetn = 1'b1;

      // Round-robin with all requesters valid.
      grants = 0;
      rsps   = 0;
      multi  = 0;
      for (int k = 0; k < 6; k++) begin
         gq[k] = 99;
         rq[k] = 99;
      end
      @(negedge clk);
      for (int k = 0; k < R; k++) set_req(k, 4'd8, 8'(k), 8'(k));
      #1;
      for (int cyc = 0; cyc < 60 && rsps < 6; cyc++) begin
         if ($countones(req_ready) > 1) multi++;
         if (req_ready != '0 && grants < 6) begin
            for (int k = 0; k < R; k++) if (req_ready[k]) gq[grants] = k;
            grants++;
         end
         if (rsp_valid && rsp_ready) begin
            rq[rsps] = int'(rsp_id);
            rsps++;
         end
         @(negedge clk);
         if (grants == 6) req_valid = '0;
         #1;
      end
      req_valid = '0;
      check("rr_multi_hot", 32'(multi), 32'd0);
      for (int k = 0; k < 6; k++) begin
         check($sformatf("rr_grant%0d", k), 32'(gq[k]), 32'(rr_exp[k]));
         check($sformatf("rr_rsp_id%0d", k), 32'(rq[k]), 32'(rr_exp[k]));
      end

      // Signed vs unsigned on the same operands.
      do_req("ult", 0, 4'd2, 8'h05, 8'h80, c, e, id);
      check("ult_c", 32'(c), 32'd1);
      check("ult_id", 32'(id), 32'd0);
      do_req("slt", 0, 4'd6, 8'h05, 8'h80, c, e, id);
      check("slt_c", 32'(c), 32'd0);
      check("slt_err", 32'(e), 32'd0);

      // Ordered operators with A=0xFF, B=0x00.
      for (int op = 0; op < 8; op++) begin
         do_req($sformatf("ff00_op%0d", op), 1, 4'(op), 8'hFF, 8'h00, c, e, id);
         check($sformatf("ff00_op%0d_c", op), 32'(c), 32'(ff00_exp[op]));
      end
      for (int k = 0; k < 4; k++) begin
         do_req($sformatf("ffff_op%0d", ffff_op[k]), 1, ffff_op[k], 8'hFF, 8'hFF, c, e, id);
         check($sformatf("ffff_op%0d_c", ffff_op[k]), 32'(c), 32'(ffff_exp[k]));
      end

      // Illegal opcode, then a legal one from the same requester.
      do_req("ill", 2, 4'd12, 8'h01, 8'h01, c, e, id);
      check("ill_err", 32'(e), 32'd1);
      check("ill_c", 32'(c), 32'd0);
      check("ill_id", 32'(id), 32'd2);
      do_req("post_ill", 2, 4'd9, 8'h01, 8'h02, c, e, id);
      check("post_ill_err", 32'(e), 32'd0);
      check("post_ill_c", 32'(c), 32'd1);

      // Backpressure: response held 5 cycles while requester 3 waits.
      @(negedge clk);
      rsp_ready = 1'b0;
      set_req(1, 4'd0, 8'h09, 8'h03);
      #1;
      wait_grant("bp", 1, ok);
      @(negedge clk);
      req_valid[1] = 1'b0;
      set_req(3, 4'd8, 8'h05, 8'h05);
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         #1;
         check($sformatf("bp_valid%0d", k), 32'(rsp_valid), 32'd1);
         check($sformatf("bp_c%0d", k), 32'(rsp_c), 32'd1);
         check($sformatf("bp_id%0d", k), 32'(rsp_id), 32'd1);
         check($sformatf("bp_rdy%0d", k), 32'(req_ready), 32'd0);
      end
      rsp_ready = 1'b1;
      @(negedge clk);
      #1;
      check("bp_next_grant", 32'(req_ready), 32'b1000);
      @(negedge clk);
      req_valid[3] = 1'b0;
      check("bp_next_exec", 32'(rsp_valid), 32'd0);
      @(negedge clk);
      check("bp_next_valid", 32'(rsp_valid), 32'd1);
      check("bp_next_id", 32'(rsp_id), 32'd3);
      check("bp_next_c", 32'(rsp_c), 32'd1);

      // Reset while in RESP with requester 1 (pointer would otherwise be 2).
      @(negedge clk);
      rsp_ready = 1'b0;
      set_req(1, 4'd0, 8'h01, 8'h00);
      #1;
      wait_grant("rst1", 1, ok);
      @(negedge clk);
      req_valid[1] = 1'b0;
      @(negedge clk);
      #1;
      check("rst1_pre_valid", 32'(rsp_valid), 32'd1);
      #1;
      resetn = 1'b0;
      #1;
      check("rst1_valid_drop", 32'(rsp_valid), 32'd0);
      @(negedge clk);
      resetn    = 1'b1;
      rsp_ready = 1'b1;
      set_req(1, 4'd8, 8'h00, 8'h00);
      set_req(3, 4'd8, 8'h00, 8'h00);
      #1;
      check("rst1_ptr_zero", 32'(req_ready), 32'b0010);
      req_valid = '0;

      // Reset in EXEC with requester 3 in flight.
      @(negedge clk);
      set_req(3, 4'd0, 8'h02, 8'h01);
      #1;
      wait_grant("rst3", 3, ok);
      @(negedge clk);
      req_valid[3] = 1'b0;
      #1;
      resetn = 1'b0;
      #1;
      check("rst3_valid", 32'(rsp_valid), 32'd0);
      check("rst3_ready", 32'(req_ready), 32'd0);
      set_req(1, 4'd9, 8'h01, 8'h00);
      set_req(3, 4'd9, 8'h01, 8'h00);
      @(negedge clk);
      #1;
      check("rst3_hold_ready", 32'(req_ready), 32'd0);
      check("rst3_hold_valid", 32'(rsp_valid), 32'd0);
      resetn = 1'b1;
      #1;
      check("rst3_first_grant", 32'(req_ready), 32'b0010);
      @(negedge clk);
      req_valid = '0;
      check("rst3_exec", 32'(rsp_valid), 32'd0);
      @(negedge clk);
      check("rst3_rsp_valid", 32'(rsp_valid), 32'd1);
      check("rst3_rsp_id", 32'(rsp_id), 32'd1);
      cnt = 0;
      for (int k = 0; k < 8; k++) begin
         @(negedge clk);
         if (rsp_valid) cnt++;
      end
      check("rst3_no_stale_rsp", 32'(cnt), 32'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
